core_irq_ctrl: RTL and testbench

Per-core interrupt controller that sits directly downstream of the core's interval timer and other peripheral IRQ sources, and upstream of the CPU's interrupt input. It synchronises up to 16 raw IRQ lines and latches edge- or level-type requests into a pending register. Masked requests are combined into a single registered `irq_out`. Software sees a 16-bit Avalon-MM slave with a priority-encoded active-ID register and a saturating interrupt counter.

---
 rtl/core_irq_pkg.sv | 17 +
 rtl/core_irq_ctrl_sync.sv | 29 ++
 rtl/core_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_core_irq_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_irq_pkg.sv
// Shared constants for the per-core interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_irq_pkg;

    localparam int IRQ_MAX = 16;

    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_PENDING   = 3'd1;
    localparam logic [2:0] ADDR_MASK      = 3'd2;
    localparam logic [2:0] ADDR_EDGE      = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE_ID = 3'd4;
    localparam logic [2:0] ADDR_COUNT     = 3'd5;

    localparam logic [15:0] COUNT_SAT = 16'hFFFF;

endpackage

// File: rtl/core_irq_ctrl_sync.sv
// Two-flop synchroniser for asynchronous request lines.
// Latency: 2 clk from the first capturing edge.
// Backpressure: none, free running.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability chain: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/core_irq_ctrl.sv
// Per-core IRQ controller: sync, edge/level latch, mask, combined irq_out, CSRs.
// Latency: irq_in to irq_out 4 clk; register read 1 clk.
// Backpressure: none; slave accepts every access, no wait states.
module core_irq_ctrl
    import core_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] sync_d_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] act;
    logic [NUM_IRQ-1:0] wdata;
    logic               irq_out_q, irq_out_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        readdata_q, readdata_d;
    logic [3:0]         act_id;
    logic               act_any;
    logic               wr_en;
    logic               unused_wdata;

    // Widen a per-source vector to the 16-bit register view, upper bits zero.
    function automatic logic [15:0] ext(input logic [NUM_IRQ-1:0] v);
        ext = '0;
        ext[NUM_IRQ-1:0] = v;
    endfunction

    irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (irq_in),
        .sync_o  (sync)
    );

    assign wr_en        = chipselect && !write_n;
    assign wdata        = writedata[NUM_IRQ-1:0];
    assign unused_wdata = ^writedata;
    assign rise         = sync & ~sync_d_q;
    assign w1c          = (wr_en && address == ADDR_PENDING) ? wdata : '0;
    assign act          = pend_q & mask_q;

    // Pending update: edge sources latch (set beats W1C), level sources track sync.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (edge_q[i]) begin
                pend_d[i] = rise[i] | (pend_q[i] & ~w1c[i]);
            end else begin
                pend_d[i] = sync[i];
            end
        end
    end

    // Control register writes and the saturating rise counter.
    always_comb begin
        mask_d    = mask_q;
        edge_d    = edge_q;
        count_d   = count_q;
        irq_out_d = |act;
        if (wr_en && address == ADDR_MASK) mask_d = wdata;
        if (wr_en && address == ADDR_EDGE) edge_d = wdata;
        if (wr_en && address == ADDR_COUNT) begin
            count_d = '0;
        end else if (!irq_out_q && irq_out_d && count_q != COUNT_SAT) begin
            count_d = count_q + 16'd1;
        end
    end

    // Priority encoder: lowest enabled pending index wins.
    always_comb begin
        act_id  = '0;
        act_any = |act;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) act_id = 4'(i);
        end
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATUS:    readdata_d = ext(sync);
            ADDR_PENDING:   readdata_d = ext(pend_q);
            ADDR_MASK:      readdata_d = ext(mask_q);
            ADDR_EDGE:      readdata_d = ext(edge_q);
            ADDR_ACTIVE_ID: readdata_d = act_any ? {1'b1, 11'd0, act_id} : 16'd0;
            ADDR_COUNT:     readdata_d = count_q;
            default:        readdata_d = '0;
        endcase
    end

    // State registers; reset also discards any pending requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d_q   <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            irq_out_q  <= 1'b0;
            count_q    <= '0;
            readdata_q <= '0;
        end else begin
            sync_d_q   <= sync;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            irq_out_q  <= irq_out_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign irq_out  = irq_out_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Directed bench for core_irq_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq_out;

    int total = 0;
    int bad   = 0;

    core_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        address    = a;
        writedata  = v;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            total++;
            if (d !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read addr=%0d got=%h exp=0000", a, d);
            end
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq_out got=%b exp=0", irq_out);
        end
    endtask

    task automatic test_reset_hold;
        logic [15:0] exp;
        @(negedge clk);
        reset_n = 1'b0;
        irq_in  = 8'hFF;
        cyc(2);
        reset_n = 1'b1;
        address = 3'd1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp = (k < 4) ? 16'h0000 : 16'h00FF;
            total++;
            if (readdata !== exp) begin
                bad++;
                $display("FAIL reset_hold_pending edge=%0d got=%h exp=%h", k, readdata, exp);
            end
        end
        irq_in = 8'h00;
        cyc(4);
    endtask

    task automatic test_edge;
        logic [15:0] d;
        wr(3'd3, 16'h0001);
        wr(3'd2, 16'h0001);
        irq_in[0] = 1'b1;
        cyc(3);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL edge_irq_out_early got=%b exp=0", irq_out);
        end
        irq_in[0] = 1'b0;
        cyc(1);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL edge_irq_out_4clk got=%b exp=1", irq_out);
        end
        cyc(3);
        rd(3'd1, d);
        total++;
        if (d !== 16'h0001) begin
            bad++;
            $display("FAIL edge_pending_held got=%h exp=0001", d);
        end
        wr(3'd1, 16'h0001);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL edge_w1c_same_cycle got=%b exp=1", irq_out);
        end
        cyc(1);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL edge_w1c_drop got=%b exp=0", irq_out);
        end
        rd(3'd5, d);
        total++;
        if (d !== 16'h0001) begin
            bad++;
            $display("FAIL edge_count got=%h exp=0001", d);
        end
    endtask

    task automatic test_level;
        logic [15:0] d;
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0004);
        irq_in[2] = 1'b1;
        cyc(4);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL level_irq_out got=%b exp=1", irq_out);
        end
        rd(3'd4, d);
        total++;
        if (d !== 16'h8002) begin
            bad++;
            $display("FAIL level_active_id got=%h exp=8002", d);
        end
        wr(3'd1, 16'h0004);
        rd(3'd1, d);
        total++;
        if (d !== 16'h0004) begin
            bad++;
            $display("FAIL level_w1c_ignored got=%h exp=0004", d);
        end
        irq_in[2] = 1'b0;
        cyc(2);
        rd(3'd1, d);
        total++;
        if (d !== 16'h0004) begin
            bad++;
            $display("FAIL level_drop_early got=%h exp=0004", d);
        end
        rd(3'd1, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL level_drop_3clk got=%h exp=0000", d);
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL level_irq_out_drop got=%b exp=0", irq_out);
        end
    endtask

    task automatic test_priority;
        logic [15:0] d;
        wr(3'd3, 16'h0028);
        wr(3'd2, 16'h0028);
        irq_in = 8'h28;
        cyc(2);
        irq_in = 8'h00;
        cyc(4);
        rd(3'd4, d);
        total++;
        if (d !== 16'h8003) begin
            bad++;
            $display("FAIL prio_both got=%h exp=8003", d);
        end
        wr(3'd1, 16'h0008);
        rd(3'd4, d);
        total++;
        if (d !== 16'h8005) begin
            bad++;
            $display("FAIL prio_after_clear got=%h exp=8005", d);
        end
        wr(3'd2, 16'h0000);
        rd(3'd4, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL prio_masked got=%h exp=0000", d);
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL prio_masked_irq_out got=%b exp=0", irq_out);
        end
        rd(3'd1, d);
        total++;
        if (d !== 16'h0020) begin
            bad++;
            $display("FAIL prio_pending_kept got=%h exp=0020", d);
        end
        wr(3'd1, 16'h0020);
    endtask

    task automatic test_collision;
        logic [15:0] d;
        wr(3'd3, 16'h0002);
        wr(3'd2, 16'h0002);
        irq_in[1] = 1'b1;
        cyc(2);
        wr(3'd1, 16'h0002);
        wr(3'd5, 16'h0000);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL coll_irq_out got=%b exp=1", irq_out);
        end
        rd(3'd1, d);
        total++;
        if (d !== 16'h0002) begin
            bad++;
            $display("FAIL coll_set_wins got=%h exp=0002", d);
        end
        rd(3'd5, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL coll_count_clear got=%h exp=0000", d);
        end
        irq_in[1] = 1'b0;
        cyc(3);
        wr(3'd1, 16'h0002);
        cyc(2);
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0001);
        wr(3'd5, 16'h0000);
        for (int p = 0; p < 5; p++) begin
            irq_in[0] = 1'b1;
            cyc(1);
            irq_in[0] = 1'b0;
            cyc(1);
        end
        cyc(4);
        rd(3'd5, d);
        total++;
        if (d !== 16'd5) begin
            bad++;
            $display("FAIL b2b_count got=%h exp=0005", d);
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_irq_out got=%b exp=0", irq_out);
        end
    endtask

    task automatic test_saturation;
        logic [15:0] d;
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        for (int p = 0; p < 3; p++) begin
            irq_in[0] = 1'b1;
            cyc(2);
            irq_in[0] = 1'b0;
            cyc(6);
            rd(3'd5, d);
            total++;
            if (d !== 16'hFFFF) begin
                bad++;
                $display("FAIL sat_count pulse=%0d got=%h exp=ffff", p, d);
            end
        end
        irq_in[0] = 1'b1;
        cyc(4);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL sat_pre_reset_irq_out got=%b exp=1", irq_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (irq_out !== 1'b0 || readdata !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset got irq_out=%b readdata=%h exp 0/0000", irq_out, readdata);
        end
        @(negedge clk);
        irq_in = 8'h00;
        cyc(1);
        reset_n = 1'b1;
        rd(3'd5, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL reset_count got=%h exp=0000", d);
        end
        rd(3'd1, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL reset_pending got=%h exp=0000", d);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = 8'h00;
        test_reset();
        test_reset_hold();
        test_edge();
        test_level();
        test_priority();
        test_collision();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
